// File: rtl/bp_cfg_table_streamer.sv
// Streams one packed config record from a parameter table as data_width_p-bit beats, LSB beat first.
// Optional build macro BP_CFG_STREAM_CHECKSUM_EN appends an XOR checksum beat to valid-id responses.
module bp_cfg_table_streamer #(
    parameter int num_cfgs_p   = 12,
    parameter int max_cfgs_p   = 128,
    parameter int cfg_width_p  = 256,
    parameter int data_width_p = 64,
    parameter logic [num_cfgs_p*cfg_width_p-1:0] cfg_table_p = '0,
    localparam int lg_max_cfgs_lp = $clog2(max_cfgs_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [lg_max_cfgs_lp-1:0] req_id_i,
    input  logic                      req_v_i,
    output logic                      req_ready_o,
    output logic [data_width_p-1:0]   data_o,
    output logic                      v_o,
    output logic                      last_o,
    output logic                      err_o,
    input  logic                      ready_i,
    output logic                      busy_o
);

    localparam int beats_lp = (cfg_width_p + data_width_p - 1) / data_width_p;
    localparam int pad_w_lp = beats_lp * data_width_p;
    localparam int cnt_w_lp = $clog2(beats_lp + 1);
`ifdef BP_CFG_STREAM_CHECKSUM_EN
    localparam int resp_beats_lp = beats_lp + 1;
`else
    localparam int resp_beats_lp = beats_lp;
`endif
    localparam logic [cnt_w_lp-1:0]       last_cnt_lp = cnt_w_lp'(resp_beats_lp - 1);
    localparam logic [lg_max_cfgs_lp:0]   num_cfgs_lp = (lg_max_cfgs_lp + 1)'(num_cfgs_p);

    typedef enum logic [1:0] {IDLE, STREAM, ERR} state_e;

    state_e                    state_q, state_d;
    logic [cnt_w_lp-1:0]       cnt_q, cnt_d;
    logic [lg_max_cfgs_lp-1:0] id_q, id_d;
    logic [data_width_p-1:0]   data_q, data_d;
    logic                      v_q, v_d, last_q, last_d, err_q, err_d;
    logic                      id_ok;

    // Record is zero-padded up to a whole number of beats before slicing.
    function automatic logic [data_width_p-1:0] beat_of(input logic [lg_max_cfgs_lp-1:0] id,
                                                        input int idx);
        logic [pad_w_lp-1:0] rec;
        rec = '0;
        if ({1'b0, id} < num_cfgs_lp)
            rec[cfg_width_p-1:0] = cfg_table_p[int'(id)*cfg_width_p +: cfg_width_p];
        return rec[idx*data_width_p +: data_width_p];
    endfunction

`ifdef BP_CFG_STREAM_CHECKSUM_EN
    function automatic logic [data_width_p-1:0] checksum_of(input logic [lg_max_cfgs_lp-1:0] id);
        logic [data_width_p-1:0] x;
        x = '0;
        for (int b = 0; b < beats_lp; b++)
            x ^= beat_of(id, b);
        return x;
    endfunction
`endif

    function automatic logic [data_width_p-1:0] next_beat(input logic [lg_max_cfgs_lp-1:0] id,
                                                          input int idx);
`ifdef BP_CFG_STREAM_CHECKSUM_EN
        if (idx >= beats_lp)
            return checksum_of(id);
`endif
        return beat_of(id, idx);
    endfunction

    assign id_ok = (req_id_i != '0) && ({1'b0, req_id_i} < num_cfgs_lp);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        data_d  = data_q;
        v_d     = v_q;
        last_d  = last_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_v_i) begin
                    cnt_d = '0;
                    v_d   = 1'b1;
                    if (id_ok) begin
                        state_d = STREAM;
                        id_d    = req_id_i;
                        data_d  = next_beat(req_id_i, 0);
                        last_d  = (last_cnt_lp == '0);
                        err_d   = 1'b0;
                    end else begin
                        state_d = ERR;
                        data_d  = '0;
                        last_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (ready_i) begin
                    if (cnt_q == last_cnt_lp) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        data_d  = '0;
                        v_d     = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        data_d = next_beat(id_q, int'(cnt_q) + 1);
                        last_d = ((cnt_q + 1'b1) == last_cnt_lp);
                    end
                end
            end
            ERR: begin
                if (ready_i) begin
                    state_d = IDLE;
                    v_d     = 1'b0;
                    last_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
            v_q     <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            data_q  <= data_d;
            v_q     <= v_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign data_o      = data_q;
    assign v_o         = v_q;
    assign last_o      = last_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_bp_cfg_table_streamer.sv
// Randomized and directed checks of bp_cfg_table_streamer (256-bit and 200-bit records) against a
// record-level reference model.
module tb_bp_cfg_table_streamer;

    localparam int NC = 12;
`ifdef BP_CFG_STREAM_CHECKSUM_EN
    localparam int RESP = 5;
`else
    localparam int RESP = 4;
`endif

    // Reference record k: entry 2 = A0..A3, entry 3 = 1,2,4,8, others a dense pattern.
    function automatic logic [255:0] rec(int k);
        logic [255:0] r;
        logic [63:0]  x;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            if (k == 2)      x = 64'hA0 + 64'(b);
            else if (k == 3) x = 64'd1 << b;
            else             x = {8'(k + 1), 8'(b), 16'hBEEF,
                                  32'(k) * 32'h9E3779B1 + 32'(b) * 32'h7F4A7C15};
            r[b*64 +: 64] = x;
        end
        return r;
    endfunction

    function automatic logic [NC*256-1:0] mk_a();
        logic [NC*256-1:0] t;
        for (int k = 0; k < NC; k++) t[k*256 +: 256] = rec(k);
        return t;
    endfunction

    function automatic logic [NC*200-1:0] mk_b();
        logic [NC*200-1:0] t;
        logic [255:0]      r;
        for (int k = 0; k < NC; k++) begin
            r = rec(k);
            t[k*200 +: 200] = r[199:0];
        end
        return t;
    endfunction

    localparam logic [NC*256-1:0] TBL_A = mk_a();
    localparam logic [NC*200-1:0] TBL_B = mk_b();

    // Expected beat idx of record id truncated to width bits; idx 4 is the XOR of the data beats.
    function automatic logic [63:0] exp_beat(int id, int width, int idx);
        logic [255:0] r;
        logic [63:0]  x;
        r = rec(id);
        if (width < 256) r = r & ((256'd1 << width) - 256'd1);
        if (idx < 4) return r[idx*64 +: 64];
        x = '0;
        for (int b = 0; b < 4; b++) x ^= r[b*64 +: 64];
        return x;
    endfunction

    logic        clk = 1'b0;
    logic        reset, req_v, ready;
    logic [6:0]  req_id;
    logic [63:0] data_a, data_b;
    logic        v_a, last_a, err_a, rr_a, busy_a;
    logic        v_b, last_b, err_b, rr_b, busy_b;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    bp_cfg_table_streamer #(.num_cfgs_p(NC), .max_cfgs_p(128), .cfg_width_p(256),
                            .data_width_p(64), .cfg_table_p(TBL_A)) dut_a (
        .clk_i(clk), .reset_i(reset), .req_id_i(req_id), .req_v_i(req_v),
        .req_ready_o(rr_a), .data_o(data_a), .v_o(v_a), .last_o(last_a), .err_o(err_a),
        .ready_i(ready), .busy_o(busy_a));

    bp_cfg_table_streamer #(.num_cfgs_p(NC), .max_cfgs_p(128), .cfg_width_p(200),
                            .data_width_p(64), .cfg_table_p(TBL_B)) dut_b (
        .clk_i(clk), .reset_i(reset), .req_id_i(req_id), .req_v_i(req_v),
        .req_ready_o(rr_b), .data_o(data_b), .v_o(v_b), .last_o(last_b), .err_o(err_b),
        .ready_i(ready), .busy_o(busy_b));

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(string tag);
        chk({tag, "_v_a"}, 64'(v_a), 64'd0);
        chk({tag, "_rr_a"}, 64'(rr_a), 64'd1);
        chk({tag, "_busy_a"}, 64'(busy_a), 64'd0);
        chk({tag, "_v_b"}, 64'(v_b), 64'd0);
        chk({tag, "_rr_b"}, 64'(rr_b), 64'd1);
        chk({tag, "_busy_b"}, 64'(busy_b), 64'd0);
    endtask

    // mode 0: ready always high; 1: ready pattern 1,0,0,...; 2: random ready plus stray requests.
    task automatic transact(int id, int mode);
        bit          valid;
        int          n, i, cyc, pat;
        bit          rdy;
        logic [63:0] ea, eb;
        valid = (id >= 1) && (id < NC);
        n     = valid ? RESP : 1;
        i     = 0;
        cyc   = 0;
        pat   = 0;
        chk_idle("pre");
        req_id = 7'(id);
        req_v  = 1'b1;
        ready  = 1'b0;
        @(negedge clk);
        req_v = 1'b0;
        while (i < n && cyc < 200) begin
            ea = valid ? exp_beat(id, 256, i) : 64'd0;
            eb = valid ? exp_beat(id, 200, i) : 64'd0;
            chk("data_a", data_a, ea);
            chk("data_b", data_b, eb);
            chk("v_a", 64'(v_a), 64'd1);
            chk("last_a", 64'(last_a), 64'(i == n - 1));
            chk("err_a", 64'(err_a), 64'(!valid));
            chk("busy_rr_a", {62'd0, busy_a, rr_a}, 64'd2);
            chk("vle_b", {61'd0, v_b, last_b, err_b}, {61'd0, 1'b1, 1'(i == n - 1), 1'(!valid)});
            chk("busy_rr_b", {62'd0, busy_b, rr_b}, 64'd2);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (pat % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            pat++;
            if (mode == 2) begin
                req_v  = 1'($urandom_range(0, 1));
                req_id = 7'($urandom_range(0, 127));
            end
            ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) i++;
        end
        req_v = 1'b0;
        ready = 1'b0;
        chk("beat_count_or_timeout", 64'(i), 64'(n));
        chk_idle("post");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int id, mode;
        reset  = 1'b1;
        req_v  = 1'b0;
        ready  = 1'b0;
        req_id = '0;
        repeat (3) @(negedge clk);
        chk("rst_data_a", data_a, 64'd0);
        chk("rst_le_a", {62'd0, last_a, err_a}, 64'd0);
        chk("rst_data_b", data_b, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk_idle("after_reset");

        transact(2, 0);
        transact(2, 1);
        transact(0, 0);
        transact(12, 0);
        transact(127, 1);
        transact(3, 0);
        transact(7, 1);

        // Reset while beat 2 is presented aborts the stream.
        req_id = 7'd2;
        req_v  = 1'b1;
        ready  = 1'b1;
        @(negedge clk);
        req_v = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_beat2", data_a, exp_beat(2, 256, 2));
        reset = 1'b1;
        @(negedge clk);
        chk_idle("midrst");
        chk("midrst_data", data_a, 64'd0);
        reset = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        chk_idle("midrst_release");

        for (int t = 0; t < 40; t++) begin
            id   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127))
                                               : int'($urandom_range(0, 13));
            mode = int'($urandom_range(0, 2));
            transact(id, mode);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
